event_sequencer: RTL

- Programmable timed-event scheduler. Produces a fixed list of one-cycle event strobes at programmed clock offsets after a start command.
- Also drives a shared toggle register, which flips on every event.
- Sits in front of event-driven datapath logic (a register that toggles on each event) and replaces hand-placed delayed triggers with a configurable, synthesizable sequence.
- Delay slots are written through a ready/valid config port while the sequencer is idle.

---
 rtl/event_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/event_sequencer.sv
// Timed-event scheduler: fires one-cycle strobes at programmed offsets
// after start, flipping a shared toggle register on each event.
module event_sequencer #(
    parameter int NUM_SLOTS = 4,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             ev_pulse,
    output logic [IDX_W-1:0] ev_idx,
    output logic             tog_q,
    output logic             done,
    output logic             err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] slot [NUM_SLOTS];
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nidx;
    logic             hit;
    logic             last;
    logic             bad;

    assign cfg_ready = (state == IDLE) & ~start;

    // nidx wraps on the final slot, but last masks that case
    assign nidx = idx + 1'b1;
    assign hit  = (cnt == slot[idx]);
    assign last = (idx == IDX_W'(NUM_SLOTS - 1)) || (slot[nidx] == '0);
    assign bad  = (slot[nidx] <= slot[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= '0;
            cnt      <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            ev_pulse <= 1'b0;
            ev_idx   <= '0;
            tog_q    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            ev_pulse <= 1'b0;
            done     <= 1'b0;
            if (cfg_we && cfg_ready) slot[cfg_addr] <= cfg_data;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (slot[0] == '0) begin
                            done <= 1'b1;
                        end else begin
                            cnt   <= CNT_W'(1);
                            idx   <= '0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (hit) begin
                            ev_pulse <= 1'b1;
                            ev_idx   <= idx;
                            tog_q    <= ~tog_q;
                            if (last || bad) begin
                                err   <= err | (~last & bad);
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                idx <= nidx;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
